rocker_drive: RTL

Actuator-side end of the rocker command interface. It consumes the level commands Fplus, Fmin and Amin from the rocking controller and holds the current rocking frequency and amplitude. It generates the motor direction and PWM drive, and returns the Flow swing-phase signal that the controller samples. It sits between the controller and the motor driver pins.

---
 rtl/rocker_drive_if.sv | 11 +
 rtl/rocker_drive.sv | 119 +++++++++++
 2 files changed

// File: rtl/rocker_drive_if.sv
// Level-command link between the rocking controller and the actuator-side drive.
// The controller drives Fplus/Fmin/Amin and samples the Flow swing phase.
interface rocker_drive_if;
    logic Fplus;
    logic Fmin;
    logic Amin;
    logic Flow;

    modport master (output Fplus, output Fmin, output Amin, input Flow);
    modport slave  (input Fplus, input Fmin, input Amin, output Flow);
endinterface

// File: rtl/rocker_drive.sv
// Rocker actuator drive: holds frequency/amplitude levels, times the swing
// half-periods, and produces motor direction plus amplitude-scaled PWM.
module rocker_drive #(
    parameter int FREQ_W = 4,
    parameter int AMP_W  = 4,
    parameter int BASE   = 4,
    parameter int F_INIT = 8,
    parameter int A_INIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    rocker_drive_if.slave     cmd,
    output logic              motor_dir,
    output logic              motor_pwm,
    output logic              period_end,
    output logic [FREQ_W-1:0] freq,
    output logic [AMP_W-1:0]  amp,
    output logic              at_limit
);

    localparam int PRE_W = (BASE > 1) ? $clog2(BASE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(BASE - 1);
    localparam logic [FREQ_W-1:0] FMAX     = '1;
    localparam logic [AMP_W-1:0]  AMAX     = '1;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [FREQ_W-1:0] unit_q, unit_d;
    logic [AMP_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic              rec_q, rec_d;
    logic              flow_q, flow_d;
    logic              pend_q, pend_d;
    logic              pwm_q, pwm_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [AMP_W-1:0]  amp_q, amp_d;

    logic [FREQ_W-1:0] unit_last;
    logic              pre_wrap;
    logic              half_end;

    always_comb begin
        freq_d = freq_q;
        amp_d  = amp_q;
        rec_d  = rec_q;
        if (pend_q) begin
            if (cmd.Fplus && !cmd.Fmin && (freq_q != FMAX)) begin
                freq_d = freq_q + 1'b1;
            end else if (cmd.Fmin && !cmd.Fplus && (freq_q != '0)) begin
                freq_d = freq_q - 1'b1;
            end

            // Two consecutive quiet samples earn back one amplitude step.
            if (cmd.Amin) begin
                if (amp_q != '0) begin
                    amp_d = amp_q - 1'b1;
                end
                rec_d = 1'b0;
            end else if (rec_q) begin
                if (amp_q != AMAX) begin
                    amp_d = amp_q + 1'b1;
                end
                rec_d = 1'b0;
            end else begin
                rec_d = 1'b1;
            end
        end
    end

    // Length is judged against the level the new half-period will run at,
    // so a frequency change at period_end never yields a stale-length half.
    always_comb begin
        unit_last = FMAX - freq_d;
        pre_wrap  = (pre_q == PRE_LAST);
        half_end  = pre_wrap && (unit_q >= unit_last);

        pre_d  = pre_wrap ? '0 : pre_q + 1'b1;
        unit_d = unit_q;
        if (pre_wrap) begin
            unit_d = (unit_q >= unit_last) ? '0 : unit_q + 1'b1;
        end

        flow_d    = flow_q ^ half_end;
        pend_d    = half_end && flow_q;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        pwm_d     = (pwm_cnt_q < amp_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q     <= '0;
            unit_q    <= '0;
            pwm_cnt_q <= '0;
            rec_q     <= 1'b0;
            flow_q    <= 1'b0;
            pend_q    <= 1'b0;
            pwm_q     <= 1'b0;
            freq_q    <= FREQ_W'(F_INIT);
            amp_q     <= AMP_W'(A_INIT);
        end else begin
            pre_q     <= pre_d;
            unit_q    <= unit_d;
            pwm_cnt_q <= pwm_cnt_d;
            rec_q     <= rec_d;
            flow_q    <= flow_d;
            pend_q    <= pend_d;
            pwm_q     <= pwm_d;
            freq_q    <= freq_d;
            amp_q     <= amp_d;
        end
    end

    assign cmd.Flow   = flow_q;
    assign motor_dir  = flow_q;
    assign motor_pwm  = pwm_q;
    assign period_end = pend_q;
    assign freq       = freq_q;
    assign amp        = amp_q;
    assign at_limit   = (freq_q == '0) || (freq_q == FMAX);

endmodule
